// File: rtl/kbd_spacebar_rx.sv
// rtl/kbd_spacebar_rx.sv - PS/2 keyboard receiver that tracks the spacebar (make/break/typematic).
// Optional odd-parity checking is enabled by defining KBD_PARITY_CHECK_EN.
module kbd_spacebar_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic space_pressed,
  output logic space_press,
  output logic frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, data_s1, data_s;
  logic          filt_clk, filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          frame_ok;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [TW-1:0] tcnt;
  logic          ext_pending, brk_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s  <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s  <= data_s1;
    end
  end

  // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_clk <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      filt_d <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = filt_d & ~filt_clk;

`ifdef KBD_PARITY_CHECK_EN
  logic parity_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      parity_bit <= 1'b0;
    else if (fall && state == PARITY)
      parity_bit <= data_s;
  end

  assign frame_ok = data_s & (^{shift_reg, parity_bit});
`else
  assign frame_ok = data_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      tcnt          <= '0;
      ext_pending   <= 1'b0;
      brk_pending   <= 1'b0;
      space_pressed <= 1'b0;
      space_press   <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      space_press <= 1'b0;
      frame_error <= 1'b0;

      if (state == IDLE || fall) begin
        tcnt <= '0;
      end else if (tcnt == TW'(TIMEOUT_CYCLES)) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        shift_reg   <= '0;
        tcnt        <= '0;
        frame_error <= 1'b1;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: state <= STOP;
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              frame_error <= 1'b1;
            end else if (shift_reg == 8'hE0) begin
              ext_pending <= 1'b1;
            end else if (shift_reg == 8'hF0) begin
              brk_pending <= 1'b1;
            end else begin
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
              // Extended codes never alias the spacebar, even E0 29.
              if (shift_reg == 8'h29 && !ext_pending) begin
                if (brk_pending) begin
                  space_pressed <= 1'b0;
                end else begin
                  space_pressed <= 1'b1;
                  space_press   <= ~space_pressed;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kbd_spacebar_rx.sv
// tb/tb_kbd_spacebar_rx.sv - directed self-checking bench for kbd_spacebar_rx.
module tb_kbd_spacebar_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic space_pressed, space_press, frame_error;

  int vectors = 0;
  int miscompares = 0;
  int press_cnt = 0;
  int ferr_cnt = 0;
  int p_idx, f_idx, p_width;
  logic pressed_at7;

  kbd_spacebar_rx dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .space_pressed(space_pressed), .space_press(space_press), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (space_press) press_cnt <= press_cnt + 1;
    if (frame_error) ferr_cnt <= ferr_cnt + 1;
  end

  // Stop-bit edge: record pulse positions counted in negedges after ps2_clk drops.
  task automatic send_bit(input logic b, input bit is_stop);
    ps2_data = b;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) begin
      p_idx = 0; f_idx = 0; p_width = 0; pressed_at7 = 1'bx;
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (is_stop) begin
        if (space_press) begin
          p_width++;
          if (p_idx == 0) p_idx = i;
        end
        if (frame_error && f_idx == 0) f_idx = i;
        if (i == 7) pressed_at7 = space_pressed;
      end
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(stop, 1'b1);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL reset_pressed: got %b expected 0", space_pressed); end
    vectors++; if (space_press !== 1'b0) begin miscompares++; $display("FAIL reset_press: got %b expected 0", space_press); end
    vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b expected 0", frame_error); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_press;
    int p0, f0;
    p0 = press_cnt; f0 = ferr_cnt;
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (p_idx !== 7) begin miscompares++; $display("FAIL press_latency: got %0d expected 7", p_idx); end
    vectors++; if (p_width !== 1) begin miscompares++; $display("FAIL press_width: got %0d expected 1", p_width); end
    vectors++; if (pressed_at7 !== 1'b1) begin miscompares++; $display("FAIL pressed_latency: got %b expected 1", pressed_at7); end
    vectors++; if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL press_no_ferr: got %0d expected 0", ferr_cnt - f0); end
    vectors++; if (press_cnt - p0 !== 1) begin miscompares++; $display("FAIL press_count: got %0d expected 1", press_cnt - p0); end
  endtask

  task automatic test_typematic;
    int p0;
    p0 = press_cnt;
    send_frame(8'h29, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (press_cnt - p0 !== 0) begin miscompares++; $display("FAIL typematic_repulse: got %0d expected 0", press_cnt - p0); end
    vectors++; if (space_pressed !== 1'b1) begin miscompares++; $display("FAIL typematic_held: got %b expected 1", space_pressed); end
    send_frame(8'hF0, 1'b0, 1'b1);
    vectors++; if (space_pressed !== 1'b1) begin miscompares++; $display("FAIL f0_no_change: got %b expected 1", space_pressed); end
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (pressed_at7 !== 1'b0) begin miscompares++; $display("FAIL break_latency: got %b expected 0", pressed_at7); end
    vectors++; if (p_width !== 0) begin miscompares++; $display("FAIL break_pulse: got %0d expected 0", p_width); end
    vectors++; if (press_cnt - p0 !== 0) begin miscompares++; $display("FAIL break_count: got %0d expected 0", press_cnt - p0); end
  endtask

  task automatic test_extended;
    int p0, f0;
    p0 = press_cnt; f0 = ferr_cnt;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL ext_pressed: got %b expected 0", space_pressed); end
    vectors++; if (press_cnt - p0 !== 0) begin miscompares++; $display("FAIL ext_press: got %0d expected 0", press_cnt - p0); end
    vectors++; if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL ext_ferr: got %0d expected 0", ferr_cnt - f0); end
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (p_idx !== 7) begin miscompares++; $display("FAIL ext_then_press: got %0d expected 7", p_idx); end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL ext_release: got %b expected 0", space_pressed); end
  endtask

  task automatic test_stop_error;
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    vectors++; if (f_idx !== 7) begin miscompares++; $display("FAIL stop_ferr_latency: got %0d expected 7", f_idx); end
    vectors++; if (p_idx !== 0) begin miscompares++; $display("FAIL stop_no_press: got %0d expected 0", p_idx); end
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL stop_pressed: got %b expected 0", space_pressed); end
    vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL stop_ferr_count: got %0d expected 1", ferr_cnt - f0); end
  endtask

  task automatic test_parity;
    send_frame(8'h29, 1'b1, 1'b1);
`ifdef KBD_PARITY_CHECK_EN
    vectors++; if (f_idx !== 7) begin miscompares++; $display("FAIL parity_ferr: got %0d expected 7", f_idx); end
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL parity_pressed: got %b expected 0", space_pressed); end
`else
    vectors++; if (p_idx !== 7) begin miscompares++; $display("FAIL parity_ignored_press: got %0d expected 7", p_idx); end
    vectors++; if (f_idx !== 0) begin miscompares++; $display("FAIL parity_ignored_ferr: got %0d expected 0", f_idx); end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_pending_survives_error;
    send_frame(8'h29, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b0);
    vectors++; if (f_idx !== 7) begin miscompares++; $display("FAIL pend_err_ferr: got %0d expected 7", f_idx); end
    vectors++; if (space_pressed !== 1'b1) begin miscompares++; $display("FAIL pend_err_held: got %b expected 1", space_pressed); end
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL pend_brk_kept: got %b expected 0", space_pressed); end
  endtask

  task automatic test_glitch;
    int p0, f0;
    p0 = press_cnt; f0 = ferr_cnt;
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt - f0); end
    vectors++; if (press_cnt - p0 !== 0) begin miscompares++; $display("FAIL glitch_press: got %0d expected 0", press_cnt - p0); end
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (p_idx !== 7) begin miscompares++; $display("FAIL glitch_then_frame: got %0d expected 7", p_idx); end
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h29, 1'b0, 1'b1);
  endtask

  task automatic test_timeout;
    int f0;
    f0 = ferr_cnt;
    send_partial(8'h29, 4);
    repeat (64900) @(negedge clk);
    vectors++; if (ferr_cnt - f0 !== 0) begin miscompares++; $display("FAIL timeout_early: got %0d expected 0", ferr_cnt - f0); end
    repeat (200) @(negedge clk);
    vectors++; if (ferr_cnt - f0 !== 1) begin miscompares++; $display("FAIL timeout_ferr: got %0d expected 1", ferr_cnt - f0); end
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL timeout_pressed: got %b expected 0", space_pressed); end
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (p_idx !== 7) begin miscompares++; $display("FAIL timeout_then_press: got %0d expected 7", p_idx); end
  endtask

  task automatic test_reset_mid_frame;
    send_partial(8'h29, 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (space_pressed !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pressed: got %b expected 0", space_pressed); end
    vectors++; if (space_press !== 1'b0 || frame_error !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pulses: got %b%b expected 00", space_press, frame_error); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++; if (p_idx !== 7) begin miscompares++; $display("FAIL rst_then_press: got %0d expected 7", p_idx); end
    vectors++; if (space_pressed !== 1'b1) begin miscompares++; $display("FAIL rst_then_pressed: got %b expected 1", space_pressed); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single_press;
    test_typematic;
    test_extended;
    test_stop_error;
    test_parity;
    test_pending_survives_error;
    test_glitch;
    test_timeout;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kbd_spacebar_rx.md
KBD_SPACEBAR_RX -- requirements
Module: kbd_spacebar_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: number of consecutive equal synchronized ps2_clk samples required to change the filtered clock level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65000: maximum number of clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-003 SHALL have port clk, input, 1 bit: system clock, single clock domain.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: asynchronous PS/2 keyboard clock.
REQ-006 SHALL have port ps2_data, input, 1 bit: asynchronous PS/2 keyboard data.
REQ-007 SHALL have port space_pressed, output, 1 bit: level output; 1 while the spacebar is held.
REQ-008 SHALL have port space_press, output, 1 bit: one-cycle pulse on each new spacebar press.
REQ-009 SHALL have port frame_error, output, 1 bit: one-cycle pulse when a frame is discarded.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; ps2_clk SHALL then go through a FILTER_LEN-sample glitch filter.
REQ-011 SHALL detect a falling edge as the filtered clock going 1->0; all bit sampling SHALL occur only in the cycle in which that edge is detected.
REQ-012 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-013 In IDLE, a falling edge with data=0 SHALL move the FSM to DATA; with data=1 the edge SHALL be ignored.
REQ-014 In DATA, SHALL shift 8 bits LSB-first using a 3-bit counter, and SHALL move to PARITY after bit 7.
REQ-015 In PARITY, SHALL capture the parity bit and move to STOP; in STOP, SHALL sample the stop bit and return to IDLE.
REQ-016 The byte SHALL be accepted in the STOP-edge cycle N only if stop=1 (and parity passes per REQ-025); otherwise the byte SHALL be dropped and frame_error SHALL pulse in cycle N+1.
REQ-017 A timeout counter SHALL clear on every falling edge and in IDLE; if it reaches TIMEOUT_CYCLES outside IDLE, the FSM SHALL return to IDLE, drop the partial byte and pulse frame_error once.
REQ-018 Decoder, accepted byte 0xE0: SHALL set ext_pending and change no output.
REQ-019 Decoder, accepted byte 0xF0: SHALL set brk_pending and change no output.
REQ-020 Decoder, any other accepted byte: SHALL clear both pending flags after use. Byte 0x29 with ext_pending=0 is the spacebar; all other bytes (including any code with ext_pending=1) SHALL be ignored.
REQ-021 Spacebar make (brk_pending=0): space_pressed SHALL go 1 in N+1; space_press SHALL pulse in N+1 only if space_pressed was 0.
REQ-022 Typematic repeats (0x29 while held) SHALL NOT re-pulse space_press.
REQ-023 Spacebar break (F0 29): space_pressed SHALL go 0 in N+1; no pulse.
REQ-024 A frame error or timeout SHALL NOT clear the pending flags or space_pressed.

Configuration
REQ-025 When macro KBD_PARITY_CHECK_EN is defined, SHALL check odd parity over data+parity; a mismatch SHALL drop the byte and pulse frame_error in N+1.
REQ-026 When KBD_PARITY_CHECK_EN is undefined, the parity bit SHALL be captured but ignored, and no parity logic SHALL remain.

Reset
REQ-027 While rst=0, all outputs SHALL be 0, FSM SHALL be IDLE, and counters, shift register, pending flags and synchronizers (ps2 side to 1) SHALL be cleared, asynchronously.
REQ-028 Reset mid-frame SHALL abandon the frame; after release the next start bit SHALL be received normally.

Verification
REQ-029 Frame 0x29 (valid parity, stop=1) -> space_press pulse 1 cycle and space_pressed=1, both one cycle after the STOP edge.
REQ-030 0x29 sent three times, then F0 29 -> exactly one space_press pulse; space_pressed drops to 0 after the final 0x29.
REQ-031 E0 29 -> no change on any output; a following 0x29 -> press detected.
REQ-032 With KBD_PARITY_CHECK_EN, 0x29 with wrong parity -> frame_error pulse, space_pressed stays 0; without the macro -> press detected.
REQ-033 ps2_clk stopped after 4 data bits for more than 65000 cycles -> one frame_error pulse, FSM in IDLE; next valid 0x29 -> press detected.
REQ-034 2-cycle ps2_clk glitch low while idle -> no state change; rst=0 mid-frame -> all outputs 0 immediately.
